emif_cal_status_poller: RTL and testbench

Avalon-MM master that sits directly upstream of the calibration IOSSM's cal_debug slave port. After reset or a start pulse, it polls each EMIF interface's calibration status word. It stops when every interface reports success or fail, or when a poll or response limit expires. It drives sticky per-interface status flags consumed by the memory-controller reset and ready logic.

---
 rtl/emif_cal_poll_pkg.sv | 44 ++++
 rtl/emif_cal_avmm_rd_master.sv | 54 +++++
 rtl/emif_cal_status_poller.sv | 206 ++++++++++++++++++++
 tb/tb_emif_cal_status_poller.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/emif_cal_poll_pkg.sv
// Shared types, constants and decode helpers for the EMIF calibration status poller.
package emif_cal_poll_pkg;

   localparam int CAL_STS_SUCCESS_BIT = 0;
   localparam int CAL_STS_FAIL_BIT    = 1;
   localparam int AVMM_ADDR_W         = 27;
   localparam int AVMM_DATA_W         = 32;

   typedef enum logic [2:0] {
      DELAY    = 3'd0,
      ISSUE    = 3'd1,
      WAIT_RSP = 3'd2,
      GAP      = 3'd3,
      NEXT     = 3'd4,
      DONE     = 3'd5
   } poll_state_e;

   typedef enum logic [1:0] {
      STS_PENDING = 2'd0,
      STS_SUCCESS = 2'd1,
      STS_FAIL    = 2'd2
   } cal_sts_e;

   // Fail wins when the IOSSM reports both bits at once.
   function automatic cal_sts_e decode_cal_status(input logic [AVMM_DATA_W-1:0] word);
      cal_sts_e sts;
      if (word[CAL_STS_FAIL_BIT]) begin
         sts = STS_FAIL;
      end else if (word[CAL_STS_SUCCESS_BIT]) begin
         sts = STS_SUCCESS;
      end else begin
         sts = STS_PENDING;
      end
      return sts;
   endfunction

   // Byte address of an interface status word; wraps modulo 2^27.
   function automatic logic [AVMM_ADDR_W-1:0] status_addr(input logic [AVMM_ADDR_W-1:0] base,
                                                          input logic [AVMM_ADDR_W-1:0] stride,
                                                          input logic [AVMM_ADDR_W-1:0] idx);
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/emif_cal_avmm_rd_master.sv
// Single-outstanding Avalon-MM read issue with waitrequest hold and a saturating response timer.
module emif_cal_avmm_rd_master
   import emif_cal_poll_pkg::*;
#(
   parameter int RSP_TIMEOUT = 255
) (
   input  logic                   clk_i,
   input  logic                   rst_n_i,
   input  logic                   issue_i,
   input  logic [AVMM_ADDR_W-1:0] addr_i,
   input  logic                   wait_rsp_i,
   input  logic                   waitrequest_i,
   input  logic                   rdata_valid_i,
   output logic                   read_o,
   output logic [AVMM_ADDR_W-1:0] addr_o,
   output logic                   accept_o,
   output logic                   rsp_valid_o,
   output logic                   rsp_timeout_o
);

   localparam int TMR_RAW_W = $clog2(RSP_TIMEOUT + 1);
   localparam int TMR_W     = (TMR_RAW_W < 8) ? 8 : TMR_RAW_W;
   localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RSP_TIMEOUT - 1);

   logic [TMR_W-1:0] tmr_q, tmr_d;

   // Handshake: read_o and addr_o stay stable while waitrequest_i is high; the request
   // is accepted on the cycle read_o=1 and waitrequest_i=0, flagged by accept_o.
   assign read_o      = issue_i;
   assign addr_o      = issue_i ? addr_i : '0;
   assign accept_o    = issue_i & ~waitrequest_i;
   assign rsp_valid_o = wait_rsp_i & rdata_valid_i;

   // A response arriving on the expiry cycle still counts, so valid masks the timeout.
   assign rsp_timeout_o = wait_rsp_i & ~rdata_valid_i & (tmr_q >= TMR_LAST);

   always_comb begin
      tmr_d = tmr_q;
      if (!wait_rsp_i) begin
         tmr_d = '0;
      end else if (tmr_q != '1) begin
         tmr_d = tmr_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         tmr_q <= '0;
      end else begin
         tmr_q <= tmr_d;
      end
   end

endmodule

// File: rtl/emif_cal_status_poller.sv
// Polls the IOSSM cal_debug status word of each EMIF interface and keeps sticky per-interface
// results for the memory-controller reset and ready logic.
module emif_cal_status_poller
   import emif_cal_poll_pkg::*;
#(
   parameter int                     NUM_IF      = 2,
   parameter logic [AVMM_ADDR_W-1:0] STATUS_BASE = 27'h000_0400,
   parameter logic [AVMM_ADDR_W-1:0] IF_STRIDE   = 27'h000_0100,
   parameter int                     START_DELAY = 64,
   parameter int                     POLL_GAP    = 16,
   parameter int                     POLL_LIMIT  = 4096,
   parameter int                     RSP_TIMEOUT = 255
) (
   input  logic                   cal_debug_clk,
   input  logic                   cal_debug_reset_n,
   input  logic                   start,
   output logic                   cal_debug_read,
   output logic                   cal_debug_write,
   output logic [AVMM_ADDR_W-1:0] cal_debug_addr,
   output logic [AVMM_DATA_W-1:0] cal_debug_write_data,
   output logic [3:0]             cal_debug_byteenable,
   input  logic                   cal_debug_waitrequest,
   input  logic [AVMM_DATA_W-1:0] cal_debug_read_data,
   input  logic                   cal_debug_read_data_valid,
   output logic                   busy,
   output logic                   cal_done,
   output logic [NUM_IF-1:0]      cal_success,
   output logic [NUM_IF-1:0]      cal_fail,
   output logic [NUM_IF-1:0]      poll_timeout,
   output logic                   rsp_timeout,
   output logic [2:0]             dbg_state
);

   localparam int IDX_W   = (NUM_IF > 1) ? $clog2(NUM_IF) : 1;
   localparam int PC_W    = $clog2(POLL_LIMIT + 1);
   localparam int CNT_MAX = (START_DELAY > POLL_GAP) ? START_DELAY : POLL_GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(START_DELAY - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(POLL_GAP - 1);
   localparam logic [PC_W-1:0]  PC_LIMIT   = PC_W'(POLL_LIMIT);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_IF - 1);

   poll_state_e             state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [PC_W-1:0]         poll_cnt_q, poll_cnt_d;
   logic [IDX_W-1:0]        if_idx_q, if_idx_d;
   logic [NUM_IF-1:0]       success_q, success_d;
   logic [NUM_IF-1:0]       fail_q, fail_d;
   logic [NUM_IF-1:0]       ptmo_q, ptmo_d;
   logic                    rtmo_q, rtmo_d;

   logic                    issue, wait_rsp;
   logic                    accept, rsp_valid, rsp_expired;
   logic [AVMM_ADDR_W-1:0]  req_addr;
   cal_sts_e                sts;

   assign req_addr = status_addr(STATUS_BASE, IF_STRIDE, AVMM_ADDR_W'(if_idx_q));
   assign sts      = decode_cal_status(cal_debug_read_data);

   emif_cal_avmm_rd_master #(
      .RSP_TIMEOUT (RSP_TIMEOUT)
   ) u_rd_master (
      .clk_i         (cal_debug_clk),
      .rst_n_i       (cal_debug_reset_n),
      .issue_i       (issue),
      .addr_i        (req_addr),
      .wait_rsp_i    (wait_rsp),
      .waitrequest_i (cal_debug_waitrequest),
      .rdata_valid_i (cal_debug_read_data_valid),
      .read_o        (cal_debug_read),
      .addr_o        (cal_debug_addr),
      .accept_o      (accept),
      .rsp_valid_o   (rsp_valid),
      .rsp_timeout_o (rsp_expired)
   );

   always_ff @(posedge cal_debug_clk) begin
      if (!cal_debug_reset_n) begin
         state_q    <= DELAY;
         cnt_q      <= '0;
         poll_cnt_q <= '0;
         if_idx_q   <= '0;
         success_q  <= '0;
         fail_q     <= '0;
         ptmo_q     <= '0;
         rtmo_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         poll_cnt_q <= poll_cnt_d;
         if_idx_q   <= if_idx_d;
         success_q  <= success_d;
         fail_q     <= fail_d;
         ptmo_q     <= ptmo_d;
         rtmo_q     <= rtmo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      poll_cnt_d = poll_cnt_q;
      if_idx_d   = if_idx_q;
      success_d  = success_q;
      fail_d     = fail_q;
      ptmo_d     = ptmo_q;
      rtmo_d     = rtmo_q;
      case (state_q)
         DELAY: begin
            if (cnt_q >= DELAY_LAST) begin
               cnt_d   = '0;
               state_d = ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ISSUE: begin
            if (accept) state_d = WAIT_RSP;
         end
         WAIT_RSP: begin
            if (rsp_valid) begin
               case (sts)
                  STS_SUCCESS: begin
                     success_d[if_idx_q] = 1'b1;
                     state_d             = NEXT;
                  end
                  STS_FAIL: begin
                     fail_d[if_idx_q] = 1'b1;
                     state_d          = NEXT;
                  end
                  default: begin
                     poll_cnt_d = poll_cnt_q + 1'b1;
                     if (poll_cnt_d >= PC_LIMIT) begin
                        ptmo_d[if_idx_q] = 1'b1;
                        state_d          = NEXT;
                     end else begin
                        state_d = GAP;
                     end
                  end
               endcase
            end else if (rsp_expired) begin
               rtmo_d  = 1'b1;
               state_d = DONE;
            end
         end
         GAP: begin
            if (cnt_q >= GAP_LAST) begin
               cnt_d   = '0;
               state_d = ISSUE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         NEXT: begin
            poll_cnt_d = '0;
            if (if_idx_q == IDX_LAST) begin
               state_d = DONE;
            end else begin
               if_idx_d = if_idx_q + 1'b1;
               state_d  = ISSUE;
            end
         end
         DONE: begin
            // A restart skips the power-up delay: the IOSSM is already alive.
            if (start) begin
               success_d  = '0;
               fail_d     = '0;
               ptmo_d     = '0;
               rtmo_d     = 1'b0;
               if_idx_d   = '0;
               poll_cnt_d = '0;
               cnt_d      = '0;
               state_d    = ISSUE;
            end
         end
         default: state_d = DELAY;
      endcase
   end

   always_comb begin
      issue    = 1'b0;
      wait_rsp = 1'b0;
      busy     = 1'b1;
      cal_done = 1'b0;
      case (state_q)
         ISSUE:    issue = 1'b1;
         WAIT_RSP: wait_rsp = 1'b1;
         DONE: begin
            busy     = 1'b0;
            cal_done = 1'b1;
         end
         default: ;
      endcase
   end

   assign cal_debug_write      = 1'b0;
   assign cal_debug_write_data = '0;
   assign cal_debug_byteenable = 4'hF;
   assign cal_success          = success_q;
   assign cal_fail             = fail_q;
   assign poll_timeout         = ptmo_q;
   assign rsp_timeout          = rtmo_q;
   assign dbg_state            = state_q;

endmodule

// File: tb/tb_emif_cal_status_poller.sv
// Directed bench for emif_cal_status_poller: Avalon slave model with programmable stall and latency.
`timescale 1ns/1ps
module tb_emif_cal_status_poller;
   import emif_cal_poll_pkg::*;

   localparam int          NUM_IF      = 2;
   localparam int          START_DELAY = 64;
   localparam int          POLL_GAP    = 16;
   localparam int          POLL_LIMIT  = 4;
   localparam int          RSP_TIMEOUT = 255;
   localparam logic [26:0] BASE        = 27'h000_0400;
   localparam logic [26:0] STRIDE      = 27'h000_0100;

   logic              cal_debug_clk = 1'b0;
   logic              cal_debug_reset_n;
   logic              start;
   logic              cal_debug_read;
   logic              cal_debug_write;
   logic [26:0]       cal_debug_addr;
   logic [31:0]       cal_debug_write_data;
   logic [3:0]        cal_debug_byteenable;
   logic              cal_debug_waitrequest;
   logic [31:0]       cal_debug_read_data;
   logic              cal_debug_read_data_valid;
   logic              busy;
   logic              cal_done;
   logic [NUM_IF-1:0] cal_success;
   logic [NUM_IF-1:0] cal_fail;
   logic [NUM_IF-1:0] poll_timeout;
   logic              rsp_timeout;
   logic [2:0]        dbg_state;

   int pass_cnt  = 0;
   int total_cnt = 0;
   int fail_cnt  = 0;
   int cyc       = 0;

   logic [26:0] exp_q[$];
   logic [31:0] rsp_data_q[$];
   int          acc_cyc_q[$];
   int          acc_cnt      = 0;
   int          stall_left   = 0;
   int          stall_seen   = 0;
   int          rsp_lat      = 1;
   int          rsp_due      = 0;
   bit          rsp_pending  = 1'b0;
   bit          inject_valid = 1'b0;
   logic [31:0] rsp_word     = '0;

   emif_cal_status_poller #(
      .NUM_IF      (NUM_IF),
      .STATUS_BASE (BASE),
      .IF_STRIDE   (STRIDE),
      .START_DELAY (START_DELAY),
      .POLL_GAP    (POLL_GAP),
      .POLL_LIMIT  (POLL_LIMIT),
      .RSP_TIMEOUT (RSP_TIMEOUT)
   ) dut (
      .cal_debug_clk             (cal_debug_clk),
      .cal_debug_reset_n         (cal_debug_reset_n),
      .start                     (start),
      .cal_debug_read            (cal_debug_read),
      .cal_debug_write           (cal_debug_write),
      .cal_debug_addr            (cal_debug_addr),
      .cal_debug_write_data      (cal_debug_write_data),
      .cal_debug_byteenable      (cal_debug_byteenable),
      .cal_debug_waitrequest     (cal_debug_waitrequest),
      .cal_debug_read_data       (cal_debug_read_data),
      .cal_debug_read_data_valid (cal_debug_read_data_valid),
      .busy                      (busy),
      .cal_done                  (cal_done),
      .cal_success               (cal_success),
      .cal_fail                  (cal_fail),
      .poll_timeout              (poll_timeout),
      .rsp_timeout               (rsp_timeout),
      .dbg_state                 (dbg_state)
   );

   // Clock and cycle counter
   always #5 cal_debug_clk = ~cal_debug_clk;
   always @(posedge cal_debug_clk) cyc <= cyc + 1;

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge cal_debug_clk);
      start = 1'b1;
      @(negedge cal_debug_clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!cal_done && n < budget) begin
         @(negedge cal_debug_clk);
         n++;
      end
      check("done_within_budget", 64'(cal_done), 1);
   endtask

   task automatic wait_read(input int budget, output int t);
      int n = 0;
      while (!cal_debug_read && n < budget) begin
         @(negedge cal_debug_clk);
         n++;
      end
      check("read_within_budget", 64'(cal_debug_read), 1);
      t = cyc;
   endtask

   task automatic wait_accept(input int n0, input int budget);
      int n = 0;
      while (acc_cnt == n0 && n < budget) begin
         @(negedge cal_debug_clk);
         n++;
      end
      check("accept_within_budget", 64'(acc_cnt != n0), 1);
   endtask

   // Avalon slave model and address scoreboard
   initial begin
      cal_debug_waitrequest     = 1'b0;
      cal_debug_read_data_valid = 1'b0;
      cal_debug_read_data       = '0;
      forever begin
         @(negedge cal_debug_clk);
         cal_debug_read_data_valid = 1'b0;
         cal_debug_read_data       = '0;
         if (inject_valid) begin
            cal_debug_read_data_valid = 1'b1;
            cal_debug_read_data       = 32'h1;
            inject_valid              = 1'b0;
         end else if (rsp_pending && cyc == rsp_due) begin
            cal_debug_read_data_valid = 1'b1;
            cal_debug_read_data       = rsp_word;
            rsp_pending               = 1'b0;
         end
         if (cal_debug_read) begin
            if (stall_left > 0) begin
               cal_debug_waitrequest = 1'b1;
               stall_left--;
               stall_seen++;
               check("stall_addr_hold", cal_debug_addr, (exp_q.size() > 0) ? exp_q[0] : 27'h0);
            end else begin
               cal_debug_waitrequest = 1'b0;
               acc_cnt++;
               acc_cyc_q.push_back(cyc);
               check("read_expected", 64'(exp_q.size() > 0), 1);
               if (exp_q.size() > 0) check("read_addr", cal_debug_addr, exp_q.pop_front());
               if (rsp_data_q.size() > 0) begin
                  rsp_pending = 1'b1;
                  rsp_word    = rsp_data_q.pop_front();
                  rsp_due     = cyc + rsp_lat;
               end
            end
         end else begin
            cal_debug_waitrequest = 1'b0;
         end
      end
   end

   // Directed sequence
   initial begin
      int t;
      int rel;
      int a;
      int n0;
      cal_debug_reset_n = 1'b0;
      start             = 1'b0;
      repeat (3) @(negedge cal_debug_clk);

      check("rst_read", 64'(cal_debug_read), 0);
      check("rst_addr", cal_debug_addr, 0);
      check("rst_write", 64'(cal_debug_write), 0);
      check("rst_wdata", cal_debug_write_data, 0);
      check("rst_byteenable", cal_debug_byteenable, 4'hF);
      check("rst_done", 64'(cal_done), 0);
      check("rst_success", cal_success, 0);
      check("rst_fail", cal_fail, 0);
      check("rst_poll_timeout", poll_timeout, 0);
      check("rst_rsp_timeout", 64'(rsp_timeout), 0);
      check("rst_state", dbg_state, DELAY);

      // Both interfaces succeed on the first read
      exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      rsp_data_q.push_back(32'h1);
      rsp_data_q.push_back(32'h1);
      rel = cyc;
      cal_debug_reset_n = 1'b1;
      wait_read(300, t);
      check("start_delay", 64'(t - rel), START_DELAY);
      check("busy_polling", 64'(busy), 1);
      wait_done(400);
      check("t1_success", cal_success, 2'b11);
      check("t1_fail", cal_fail, 2'b00);
      check("t1_busy", 64'(busy), 0);
      check("t1_reads_left", 64'(exp_q.size()), 0);

      // Interface 0 pending three times then fail; a start while busy is ignored
      acc_cyc_q.delete();
      rsp_lat = 2;
      repeat (4) exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      rsp_data_q.push_back(32'h0);
      rsp_data_q.push_back(32'h0);
      rsp_data_q.push_back(32'h0);
      rsp_data_q.push_back(32'h2);
      rsp_data_q.push_back(32'h1);
      pulse_start();
      check("start_clears_success", cal_success, 2'b00);
      check("start_sets_busy", 64'(busy), 1);
      repeat (5) @(negedge cal_debug_clk);
      start = 1'b1;
      @(negedge cal_debug_clk);
      start = 1'b0;
      wait_done(800);
      check("t2_fail", cal_fail, 2'b01);
      check("t2_success", cal_success, 2'b10);
      check("t2_poll_timeout", poll_timeout, 2'b00);
      check("t2_read_count", 64'(acc_cyc_q.size()), 5);
      if (acc_cyc_q.size() == 5) begin
         for (int i = 1; i < 4; i++) begin
            check("t2_poll_gap", 64'((acc_cyc_q[i] - acc_cyc_q[i-1]) > POLL_GAP), 1);
         end
      end

      // Interface 0 never resolves: poll limit reached, interface 1 still polled
      rsp_lat = $urandom_range(1, 6);
      repeat (4) exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      repeat (4) rsp_data_q.push_back(32'h0);
      rsp_data_q.push_back(32'h1);
      pulse_start();
      wait_done(800);
      check("t3_poll_timeout", poll_timeout, 2'b01);
      check("t3_success", cal_success, 2'b10);
      check("t3_fail", cal_fail, 2'b00);
      check("t3_reads_left", 64'(exp_q.size()), 0);

      // Ten waitrequest cycles on the first read
      rsp_lat    = 1;
      stall_seen = 0;
      stall_left = 10;
      n0         = acc_cnt;
      exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      rsp_data_q.push_back(32'h1);
      rsp_data_q.push_back(32'h3);
      pulse_start();
      wait_done(400);
      check("t4_stall_cycles", 64'(stall_seen), 10);
      check("t4_accepts", 64'(acc_cnt - n0), 2);
      check("t4_success", cal_success, 2'b01);
      check("t4_fail_both_bits", cal_fail, 2'b10);

      // No response: rsp_timeout exactly RSP_TIMEOUT cycles after acceptance
      acc_cyc_q.delete();
      n0 = acc_cnt;
      exp_q.push_back(BASE);
      pulse_start();
      wait_accept(n0, 50);
      a = (acc_cyc_q.size() > 0) ? acc_cyc_q[acc_cyc_q.size()-1] : cyc;
      while (cyc < a + RSP_TIMEOUT) @(negedge cal_debug_clk);
      check("t5_no_timeout_early", 64'(rsp_timeout), 0);
      check("t5_not_done_early", 64'(cal_done), 0);
      @(negedge cal_debug_clk);
      check("t5_rsp_timeout", 64'(rsp_timeout), 1);
      check("t5_done", 64'(cal_done), 1);
      check("t5_state", dbg_state, DONE);
      check("t5_success", cal_success, 2'b00);
      check("t5_fail", cal_fail, 2'b00);

      // Response on the expiry cycle is accepted
      rsp_lat = RSP_TIMEOUT;
      exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      rsp_data_q.push_back(32'h1);
      rsp_data_q.push_back(32'h1);
      pulse_start();
      check("start_clears_rsp_timeout", 64'(rsp_timeout), 0);
      wait_done(1200);
      check("t6_rsp_timeout", 64'(rsp_timeout), 0);
      check("t6_success", cal_success, 2'b11);

      // Reset during WAIT_RSP, then a late valid
      rsp_lat = 1;
      n0      = acc_cnt;
      exp_q.push_back(BASE);
      pulse_start();
      wait_accept(n0, 50);
      @(negedge cal_debug_clk);
      check("t7_in_wait_rsp", dbg_state, WAIT_RSP);
      cal_debug_reset_n = 1'b0;
      @(negedge cal_debug_clk);
      check("t7_rst_read", 64'(cal_debug_read), 0);
      check("t7_rst_state", dbg_state, DELAY);
      check("t7_rst_done", 64'(cal_done), 0);
      check("t7_rst_success", cal_success, 2'b00);
      repeat (2) @(negedge cal_debug_clk);
      exp_q.push_back(BASE);
      exp_q.push_back(BASE + STRIDE);
      rsp_data_q.push_back(32'h1);
      rsp_data_q.push_back(32'h1);
      rel = cyc;
      cal_debug_reset_n = 1'b1;
      inject_valid      = 1'b1;
      repeat (3) @(negedge cal_debug_clk);
      check("t7_late_valid_state", dbg_state, DELAY);
      check("t7_late_valid_success", cal_success, 2'b00);
      wait_read(300, t);
      check("t7_restart_delay", 64'(t - rel), START_DELAY);
      wait_done(400);
      check("t7_success", cal_success, 2'b11);
      check("final_reads_left", 64'(exp_q.size()), 0);
      check("final_rsp_left", 64'(rsp_data_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
